// File: rtl/id_stage.sv
// Instruction-decode stage: 8-entry register file with writeback bypass,
// operand-B immediate select, and the ID/EX pipeline register.
module id_stage #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IF_ID_RegWrite,
    input  logic              IF_ID_ALUSrc,
    input  logic [7:0]        IF_ID_Instruction_Code,
    input  logic [7:0]        IF_ID_Imm_Data,
    input  logic              WB_RegWrite,
    input  logic [ADDR_W-1:0] WB_Addr,
    input  logic [DATA_W-1:0] WB_Data,
    input  logic [ADDR_W-1:0] Dbg_Addr,
    output logic [DATA_W-1:0] Dbg_Data,
    output logic              ID_EX_RegWrite,
    output logic              ID_EX_ALUSrc,
    output logic [1:0]        ID_EX_Opcode,
    output logic [ADDR_W-1:0] ID_EX_Rd,
    output logic [DATA_W-1:0] ID_EX_OpA,
    output logic [DATA_W-1:0] ID_EX_OpB
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] rf_reg [NUM_REGS];

    logic [1:0]        opcode;
    logic [ADDR_W-1:0] rd;
    logic [ADDR_W-1:0] rs;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] op_b_next;

    assign opcode = IF_ID_Instruction_Code[7:6];
    assign rd     = IF_ID_Instruction_Code[5:3];
    assign rs     = IF_ID_Instruction_Code[2:0];

    // Debug port sees only the stored contents, never the bypass path.
    assign Dbg_Data = rf_reg[Dbg_Addr];

    // Register file: reset loads R[k] = k; writeback lands at the edge it is presented.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                rf_reg[k] <= DATA_W'(k);
            end
        end else if (WB_RegWrite) begin
            rf_reg[WB_Addr] <= WB_Data;
        end
    end

    // Operand fetch with writeback bypass so a same-cycle write is seen by decode.
    always_comb begin
        src_a     = rf_reg[rd];
        src_b     = rf_reg[rs];
        op_b_next = '0;
        if (WB_RegWrite && (WB_Addr == rd)) begin
            src_a = WB_Data;
        end
        if (WB_RegWrite && (WB_Addr == rs)) begin
            src_b = WB_Data;
        end
        op_b_next = IF_ID_ALUSrc ? IF_ID_Imm_Data : src_b;
    end

    // ID/EX pipeline register; bubbles (RegWrite=0) pass through untouched.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ID_EX_RegWrite <= 1'b0;
            ID_EX_ALUSrc   <= 1'b0;
            ID_EX_Opcode   <= '0;
            ID_EX_Rd       <= '0;
            ID_EX_OpA      <= '0;
            ID_EX_OpB      <= '0;
        end else begin
            ID_EX_RegWrite <= IF_ID_RegWrite;
            ID_EX_ALUSrc   <= IF_ID_ALUSrc;
            ID_EX_Opcode   <= opcode;
            ID_EX_Rd       <= rd;
            ID_EX_OpA      <= src_a;
            ID_EX_OpB      <= op_b_next;
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: reset, reads, immediate select, bypass,
// writeback gating, back-to-back hazards and reset-vs-write priority.
module tb_id_stage;

    logic       Clk;
    logic       Reset;
    logic       IF_ID_RegWrite;
    logic       IF_ID_ALUSrc;
    logic [7:0] IF_ID_Instruction_Code;
    logic [7:0] IF_ID_Imm_Data;
    logic       WB_RegWrite;
    logic [2:0] WB_Addr;
    logic [7:0] WB_Data;
    logic [2:0] Dbg_Addr;
    logic [7:0] Dbg_Data;
    logic       ID_EX_RegWrite;
    logic       ID_EX_ALUSrc;
    logic [1:0] ID_EX_Opcode;
    logic [2:0] ID_EX_Rd;
    logic [7:0] ID_EX_OpA;
    logic [7:0] ID_EX_OpB;

    int checks = 0;
    int errors = 0;

    id_stage #(.DATA_W(8), .ADDR_W(3)) dut (
        .Clk                    (Clk),
        .Reset                  (Reset),
        .IF_ID_RegWrite         (IF_ID_RegWrite),
        .IF_ID_ALUSrc           (IF_ID_ALUSrc),
        .IF_ID_Instruction_Code (IF_ID_Instruction_Code),
        .IF_ID_Imm_Data         (IF_ID_Imm_Data),
        .WB_RegWrite            (WB_RegWrite),
        .WB_Addr                (WB_Addr),
        .WB_Data                (WB_Data),
        .Dbg_Addr               (Dbg_Addr),
        .Dbg_Data               (Dbg_Data),
        .ID_EX_RegWrite         (ID_EX_RegWrite),
        .ID_EX_ALUSrc           (ID_EX_ALUSrc),
        .ID_EX_Opcode           (ID_EX_Opcode),
        .ID_EX_Rd               (ID_EX_Rd),
        .ID_EX_OpA              (ID_EX_OpA),
        .ID_EX_OpB              (ID_EX_OpB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic alusrc, input logic [7:0] instr,
                         input logic [7:0] imm, input logic wb_en, input logic [2:0] wb_a,
                         input logic [7:0] wb_d);
        IF_ID_RegWrite         = rw;
        IF_ID_ALUSrc           = alusrc;
        IF_ID_Instruction_Code = instr;
        IF_ID_Imm_Data         = imm;
        WB_RegWrite            = wb_en;
        WB_Addr                = wb_a;
        WB_Data                = wb_d;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 8'h00);
        Dbg_Addr = 3'd0;
        #2;
        tick();
        Reset = 1'b0;
        #1;
        checks++;
        if ({ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Opcode, ID_EX_Rd, ID_EX_OpA, ID_EX_OpB} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rw=%b src=%b op=%0d rd=%0d a=%h b=%h, want all 0",
                     ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Opcode, ID_EX_Rd, ID_EX_OpA, ID_EX_OpB);
        end
        for (int k = 0; k < 8; k++) begin
            Dbg_Addr = 3'(k);
            #1;
            checks++;
            if (Dbg_Data !== 8'(k)) begin
                errors++;
                $display("FAIL reset_rf[%0d]: got %h want %h", k, Dbg_Data, 8'(k));
            end
        end
        $display("txn reset: initial state checked");
    endtask

    task automatic test_register_read();
        drive(1'b1, 1'b0, 8'b01_010_011, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        checks++;
        if (ID_EX_OpA !== 8'h02 || ID_EX_OpB !== 8'h03 || ID_EX_Opcode !== 2'd1 ||
            ID_EX_Rd !== 3'd2 || ID_EX_RegWrite !== 1'b1 || ID_EX_ALUSrc !== 1'b0) begin
            errors++;
            $display("FAIL register_read: got a=%h b=%h op=%0d rd=%0d rw=%b src=%b, want a=02 b=03 op=1 rd=2 rw=1 src=0",
                     ID_EX_OpA, ID_EX_OpB, ID_EX_Opcode, ID_EX_Rd, ID_EX_RegWrite, ID_EX_ALUSrc);
        end
        $display("txn register_read: a=%h b=%h", ID_EX_OpA, ID_EX_OpB);
    endtask

    task automatic test_immediate();
        drive(1'b1, 1'b1, 8'b00_101_110, 8'hA5, 1'b0, 3'd0, 8'h00);
        tick();
        checks++;
        if (ID_EX_OpA !== 8'h05 || ID_EX_OpB !== 8'hA5 || ID_EX_ALUSrc !== 1'b1 ||
            ID_EX_Rd !== 3'd5 || ID_EX_Opcode !== 2'd0) begin
            errors++;
            $display("FAIL immediate: got a=%h b=%h src=%b rd=%0d op=%0d, want a=05 b=a5 src=1 rd=5 op=0",
                     ID_EX_OpA, ID_EX_OpB, ID_EX_ALUSrc, ID_EX_Rd, ID_EX_Opcode);
        end
        $display("txn immediate: a=%h b=%h", ID_EX_OpA, ID_EX_OpB);
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b0, 8'b10_100_100, 8'h00, 1'b1, 3'd4, 8'h3C);
        tick();
        WB_RegWrite = 1'b0;
        checks++;
        if (ID_EX_OpA !== 8'h3C || ID_EX_OpB !== 8'h3C || ID_EX_Opcode !== 2'd2) begin
            errors++;
            $display("FAIL bypass_ops: got a=%h b=%h op=%0d, want a=3c b=3c op=2",
                     ID_EX_OpA, ID_EX_OpB, ID_EX_Opcode);
        end
        Dbg_Addr = 3'd4;
        #1;
        checks++;
        if (Dbg_Data !== 8'h3C) begin
            errors++;
            $display("FAIL bypass_rf: got R4=%h want 3c", Dbg_Data);
        end
        $display("txn bypass: a=%h b=%h R4=%h", ID_EX_OpA, ID_EX_OpB, Dbg_Data);
    endtask

    task automatic test_wb_disabled();
        drive(1'b1, 1'b0, 8'b11_001_001, 8'h00, 1'b0, 3'd1, 8'hFF);
        tick();
        checks++;
        if (ID_EX_OpA !== 8'h01 || ID_EX_OpB !== 8'h01) begin
            errors++;
            $display("FAIL wb_disabled_ops: got a=%h b=%h, want a=01 b=01", ID_EX_OpA, ID_EX_OpB);
        end
        Dbg_Addr = 3'd1;
        #1;
        checks++;
        if (Dbg_Data !== 8'h01) begin
            errors++;
            $display("FAIL wb_disabled_rf: got R1=%h want 01", Dbg_Data);
        end
        $display("txn wb_disabled: a=%h R1=%h", ID_EX_OpA, Dbg_Data);
    endtask

    task automatic test_async_reset();
        // Outputs are nonzero here (a=01, rw=1); R4 holds 3c.
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Opcode, ID_EX_Rd, ID_EX_OpA, ID_EX_OpB} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got rw=%b op=%0d rd=%0d a=%h b=%h, want all 0",
                     ID_EX_RegWrite, ID_EX_Opcode, ID_EX_Rd, ID_EX_OpA, ID_EX_OpB);
        end
        for (int k = 0; k < 8; k++) begin
            Dbg_Addr = 3'(k);
            #0.5;
            checks++;
            if (Dbg_Data !== 8'(k)) begin
                errors++;
                $display("FAIL async_reset_rf[%0d]: got %h want %h", k, Dbg_Data, 8'(k));
            end
        end
        @(negedge Clk);
        Reset = 1'b0;
        $display("txn async_reset: outputs and register file checked");
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        drive(1'b1, 1'b0, 8'b01_000_010, 8'h00, 1'b1, 3'd2, 8'h11);
        tick();
        checks++;
        if (ID_EX_OpA !== 8'h00 || ID_EX_OpB !== 8'h11) begin
            errors++;
            $display("FAIL b2b_1: got a=%h b=%h, want a=00 b=11", ID_EX_OpA, ID_EX_OpB);
        end
        $display("txn b2b_1: a=%h b=%h", ID_EX_OpA, ID_EX_OpB);
        drive(1'b1, 1'b0, 8'b00_010_011, 8'h00, 1'b1, 3'd3, 8'h22);
        tick();
        checks++;
        if (ID_EX_OpA !== 8'h11 || ID_EX_OpB !== 8'h22) begin
            errors++;
            $display("FAIL b2b_2: got a=%h b=%h, want a=11 b=22", ID_EX_OpA, ID_EX_OpB);
        end
        $display("txn b2b_2: a=%h b=%h", ID_EX_OpA, ID_EX_OpB);
        drive(1'b0, 1'b0, 8'b00_011_010, 8'h00, 1'b0, 3'd0, 8'h00);
        tick();
        checks++;
        if (ID_EX_OpA !== 8'h22 || ID_EX_OpB !== 8'h11 || ID_EX_RegWrite !== 1'b0 || ID_EX_Rd !== 3'd3) begin
            errors++;
            $display("FAIL b2b_bubble: got a=%h b=%h rw=%b rd=%0d, want a=22 b=11 rw=0 rd=3",
                     ID_EX_OpA, ID_EX_OpB, ID_EX_RegWrite, ID_EX_Rd);
        end
        $display("txn b2b_bubble: a=%h b=%h rw=%b", ID_EX_OpA, ID_EX_OpB, ID_EX_RegWrite);
    endtask

    task automatic test_reset_during_write();
        @(negedge Clk);
        drive(1'b1, 1'b1, 8'b11_110_110, 8'h77, 1'b1, 3'd6, 8'h99);
        Reset = 1'b1;
        tick();
        Dbg_Addr = 3'd6;
        #1;
        checks++;
        if (Dbg_Data !== 8'h06) begin
            errors++;
            $display("FAIL reset_write_rf: got R6=%h want 06", Dbg_Data);
        end
        checks++;
        if ({ID_EX_RegWrite, ID_EX_ALUSrc, ID_EX_Opcode, ID_EX_Rd, ID_EX_OpA, ID_EX_OpB} !== 23'd0) begin
            errors++;
            $display("FAIL reset_write_outputs: got rw=%b a=%h b=%h, want all 0",
                     ID_EX_RegWrite, ID_EX_OpA, ID_EX_OpB);
        end
        Dbg_Addr = 3'd2;
        #1;
        checks++;
        if (Dbg_Data !== 8'h02) begin
            errors++;
            $display("FAIL reset_write_r2: got R2=%h want 02", Dbg_Data);
        end
        @(negedge Clk);
        WB_RegWrite = 1'b0;
        Reset = 1'b0;
        Dbg_Addr = 3'd6;
        #1;
        checks++;
        if (Dbg_Data !== 8'h06) begin
            errors++;
            $display("FAIL reset_write_release: got R6=%h want 06", Dbg_Data);
        end
        $display("txn reset_during_write: R6=%h", Dbg_Data);
    endtask

    initial begin
        test_reset();
        test_register_read();
        test_immediate();
        test_bypass();
        test_wb_disabled();
        test_async_reset();
        test_back_to_back();
        test_reset_during_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 8-bit pipelined processor, directly downstream of the IF/ID pipeline register. It consumes the registered instruction, immediate and control bits, and reads an internal 8 x 8 register file. It resolves writeback-to-decode hazards by bypassing, selects operand B (register or immediate), and registers everything into the ID/EX pipeline register feeding the execute stage. The execute stage writes its result back through the WB port.

## Interface
Parameters:
- DATA_W, 8, register/operand width
- ADDR_W, 3, register address width (2**ADDR_W registers)

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  reset, asynchronous, active-high
- IF_ID_RegWrite  input  1  instruction writes a register
- IF_ID_ALUSrc  input  1  1 = operand B is immediate, 0 = register Rs
- IF_ID_Instruction_Code  input  8  [7:6] opcode, [5:3] Rd (destination and source A), [2:0] Rs (source B)
- IF_ID_Imm_Data  input  8  immediate operand
- WB_RegWrite  input  1  writeback enable from EX stage
- WB_Addr  input  ADDR_W  writeback register index
- WB_Data  input  DATA_W  writeback value
- Dbg_Addr  input  ADDR_W  debug read index
- Dbg_Data  output  DATA_W  combinational R[Dbg_Addr], no bypass
- ID_EX_RegWrite  output  1  registered RegWrite
- ID_EX_ALUSrc  output  1  registered ALUSrc
- ID_EX_Opcode  output  2  registered opcode
- ID_EX_Rd  output  ADDR_W  registered destination index
- ID_EX_OpA  output  DATA_W  registered source-A value
- ID_EX_OpB  output  DATA_W  registered source-B value or immediate

## Operation
- Register file: 2**ADDR_W entries of DATA_W bits. No hardwired-zero register; R0 is writable.
- Reset state of the register file: R[k] = k, so R0=0x00 … R7=0x07.
- Write: on a rising Clk edge with Reset low and WB_RegWrite=1, R[WB_Addr] <= WB_Data.
- Reads are combinational.
  - rawA = R[Rd], rawB = R[Rs].
  - Bypass: if WB_RegWrite=1 and WB_Addr == Rd, srcA = WB_Data, else rawA. Apply the same rule to srcB against Rs.
  - When Rd == Rs == WB_Addr, both operands take the bypassed value.
- Operand B mux: OpB_next = IF_ID_ALUSrc ? IF_ID_Imm_Data : srcB. The Rs field is ignored when ALUSrc=1.
- Pipeline register: on each rising edge with Reset low, load:
  - ID_EX_RegWrite <= IF_ID_RegWrite
  - ID_EX_ALUSrc <= IF_ID_ALUSrc
  - ID_EX_Opcode <= Instruction_Code[7:6]
  - ID_EX_Rd <= Instruction_Code[5:3]
  - ID_EX_OpA <= srcA
  - ID_EX_OpB <= OpB_next
- No stall or flush inputs. A bubble is an instruction with RegWrite=0, and it passes through unchanged.
- The block does not interpret opcodes. Opcode meaning belongs to the EX stage.

## Timing
- Decode latency: 1 cycle. Inputs present before edge N appear on the ID_EX_* outputs after edge N.
- Writeback: takes effect in the register file at the same edge it is presented. The bypass makes the value visible to the decode in that same cycle, so there is zero hazard window.
- A simultaneous write and read of the same register at edge N:
  - ID_EX captures the new value.
  - The register file holds the new value after edge N.
- Reset asserted at any time:
  - All ID_EX_* outputs go to 0 immediately, without waiting for Clk.
  - The register file returns to R[k]=k.
  - WB writes are ignored while Reset is high.
- Reset deasserted: the first load occurs at the next rising edge.
- Dbg_Data reflects register file contents only. Written values become visible after the write edge.
- Arithmetic: none. All paths are DATA_W-bit moves with no truncation or extension.

## Test plan
- Reset check: assert Reset mid-cycle with outputs nonzero. Required: all ID_EX_* = 0 without a clock edge, and Dbg_Data for addr 0..7 reads 0x00..0x07.
- Register read: Instr=8'b01_010_011 (opcode 1, Rd=2, Rs=3), ALUSrc=0, RegWrite=1, no WB. Required after one edge: OpA=0x02, OpB=0x03, Opcode=1, Rd=2, RegWrite=1.
- Immediate select: Instr=8'b00_101_110, ALUSrc=1, Imm=0xA5. Required: OpA=0x05, OpB=0xA5, ALUSrc=1.
- Bypass: WB_RegWrite=1, WB_Addr=4, WB_Data=0x3C, same cycle as Instr Rd=4, Rs=4, ALUSrc=0. Required: OpA=OpB=0x3C after the edge, and Dbg_Data(4)=0x3C afterwards.
- WB disabled: WB_RegWrite=0, WB_Addr=1, WB_Data=0xFF. Required: R1 remains 0x01 and the Rd=1 read gives 0x01.
- Reset during write: Reset high at the edge with WB_RegWrite=1, WB_Addr=6, WB_Data=0x99. Required: R6=0x06 after reset and ID_EX_* = 0.
